// File: rtl/accumulate_pkg.sv
`default_nettype none
// ============================================================================
// accumulate_pkg : default widths, term-width derivation and signed limits
// Revision: 1.0
// ============================================================================
package accumulate_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ACC_W  = 8;

    // x*w needs 2*DATA_W bits; the extra bit absorbs the bias addition.
    function automatic int term_width(input int data_w);
        return 2 * data_w + 1;
    endfunction

    function automatic logic signed [63:0] acc_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    localparam logic signed [63:0] ACC_MAX = acc_max(DEFAULT_ACC_W);
    localparam logic signed [63:0] ACC_MIN = acc_min(DEFAULT_ACC_W);

endpackage : accumulate_pkg
`default_nettype wire

// File: rtl/accumulate_mac_stage.sv
`default_nettype none
// ============================================================================
// accumulate_mac_stage : input registers plus registered full-precision x*w+b
// Revision: 1.0
// ============================================================================
module accumulate_mac_stage
    import accumulate_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic signed [DATA_W-1:0]             x,
    input  logic signed [DATA_W-1:0]             weight,
    input  logic signed [DATA_W-1:0]             bias,
    output logic signed [term_width(DATA_W)-1:0] term
);

    localparam int TERM_W = term_width(DATA_W);

    logic signed [DATA_W-1:0] r_x;
    logic signed [DATA_W-1:0] r_w;
    logic signed [DATA_W-1:0] r_b;
    logic signed [TERM_W-1:0] w_term;

    // Operands are sign-extended first so the product is formed at full width.
    assign w_term = TERM_W'(r_x) * TERM_W'(r_w) + TERM_W'(r_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= '0;
            r_w  <= '0;
            r_b  <= '0;
            term <= '0;
        end else begin
            r_x  <= x;
            r_w  <= weight;
            r_b  <= bias;
            term <= w_term;
        end
    end

endmodule : accumulate_mac_stage
`default_nettype wire

// File: rtl/accumulate.sv
`default_nettype none
// ============================================================================
// accumulate : signed MAC with gated running accumulator (wrap by default,
//              clamp to the signed ACC_W range when ACCU_SATURATE_EN is defined)
// Revision: 1.0
// ============================================================================
module accumulate
    import accumulate_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [ACC_W-1:0]  accu
);

    localparam int TERM_W = term_width(DATA_W);
    localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;

    logic signed [TERM_W-1:0] w_term;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_next;

    accumulate_mac_stage #(
        .DATA_W (DATA_W)
    ) u_mac_stage (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .weight (weight),
        .bias   (bias),
        .term   (w_term)
    );

    assign w_sum = SUM_W'(accu) + SUM_W'(w_term);

`ifdef ACCU_SATURATE_EN
    localparam logic signed [SUM_W-1:0] C_SAT_MAX = SUM_W'(acc_max(ACC_W));
    localparam logic signed [SUM_W-1:0] C_SAT_MIN = SUM_W'(acc_min(ACC_W));

    always_comb begin
        w_next = w_sum[ACC_W-1:0];
        if (w_sum > C_SAT_MAX) begin
            w_next = C_SAT_MAX[ACC_W-1:0];
        end else if (w_sum < C_SAT_MIN) begin
            w_next = C_SAT_MIN[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        w_next = w_sum[ACC_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accu <= '0;
        end else if (en) begin
            accu <= w_next;
        end
    end

endmodule : accumulate
`default_nettype wire

// File: tb/tb_accumulate.sv
`default_nettype none
// ============================================================================
// tb_accumulate : directed and randomized checks of accumulate against a model
// Revision: 1.0
// ============================================================================
module tb_accumulate;

    localparam int ACC_W = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic signed [7:0] x;
    logic signed [7:0] weight;
    logic signed [7:0] bias;
    logic signed [7:0] accu;

    int vectors;
    int errors;

    // Reference: terms in flight (oldest first) and the expected accumulator.
    int term_q[$];
    int model_acc;

    accumulate dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .x      (x),
        .weight (weight),
        .bias   (bias),
        .accu   (accu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int reduce(input int s);
        logic [ACC_W-1:0] low;
`ifdef ACCU_SATURATE_EN
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return s;
`else
        low = s[ACC_W-1:0];
        return int'($signed(low));
`endif
    endfunction

    function automatic void model_clear();
        term_q    = '{0, 0};
        model_acc = 0;
    endfunction

    // Apply one clock edge with the given inputs; returns at edge + 1.
    task automatic step(input int xi, input int wi, input int bi, input logic e);
        int t;
        x      = 8'(xi);
        weight = 8'(wi);
        bias   = 8'(bi);
        en     = e;
        @(posedge clk);
        t = term_q.pop_front();
        if (e) model_acc = reduce(model_acc + t);
        term_q.push_back(int'(x) * int'(weight) + int'(bias));
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        x = '0; weight = '0; bias = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (accu !== 8'sd0) begin
            errors++;
            $display("FAIL reset_value: accu=%0d required=0", accu);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        step(5, 2, 1, 1'b0);
        step(5, 2, 1, 1'b0);
        step(5, 2, 1, 1'b1);
        vectors++;
        if (accu !== 8'sd11) begin
            errors++;
            $display("FAIL basic_mac: accu=%0d required=11", accu);
        end
        for (int i = 0; i < 2; i++) begin
            step(5, 2, 1, 1'b0);
            vectors++;
            if (accu !== 8'sd11) begin
                errors++;
                $display("FAIL basic_hold: accu=%0d required=11", accu);
            end
        end
    endtask

    task automatic test_repeated();
        int exp_v[3] = '{-10, -20, -30};
        do_reset();
        step(3, -4, 2, 1'b0);
        step(3, -4, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(3, -4, 2, 1'b1);
            vectors++;
            if (int'(accu) != exp_v[i]) begin
                errors++;
                $display("FAIL repeated_acc[%0d]: accu=%0d required=%0d", i, accu, exp_v[i]);
            end
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        step(7, 1, 0, 1'b0);
        step(7, 1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(7, 1, 0, 1'b0);
            vectors++;
            if (accu !== 8'sd0) begin
                errors++;
                $display("FAIL en_gating[%0d]: accu=%0d required=0", i, accu);
            end
        end
        step(7, 1, 0, 1'b1);
        vectors++;
        if (accu !== 8'sd7) begin
            errors++;
            $display("FAIL en_single: accu=%0d required=7", accu);
        end
    endtask

    task automatic test_overflow();
        int exp2;
        int expn;
`ifdef ACCU_SATURATE_EN
        exp2 = 127;
        expn = -128;
`else
        exp2 = -2;
        expn = 127;
`endif
        do_reset();
        step(100, 1, 27, 1'b0);
        step(100, 1, 27, 1'b0);
        step(100, 1, 27, 1'b1);
        vectors++;
        if (accu !== 8'sd127) begin
            errors++;
            $display("FAIL overflow_first: accu=%0d required=127", accu);
        end
        step(100, 1, 27, 1'b1);
        vectors++;
        if (int'(accu) != exp2) begin
            errors++;
            $display("FAIL overflow_second: accu=%0d required=%0d", accu, exp2);
        end
        do_reset();
        step(-128, 1, -1, 1'b0);
        step(-128, 1, -1, 1'b0);
        step(-128, 1, -1, 1'b1);
        vectors++;
        if (int'(accu) != expn) begin
            errors++;
            $display("FAIL overflow_negative: accu=%0d required=%0d", accu, expn);
        end
    endtask

    task automatic test_async_reset();
        int exp_v[3] = '{0, 0, 11};
        do_reset();
        step(5, 2, 1, 1'b0);
        step(5, 2, 1, 1'b0);
        step(5, 2, 1, 1'b1);
        step(5, 2, 1, 1'b1);
        vectors++;
        if (accu !== 8'sd22) begin
            errors++;
            $display("FAIL async_pre: accu=%0d required=22", accu);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (accu !== 8'sd0) begin
            errors++;
            $display("FAIL async_clear: accu=%0d required=0", accu);
        end
        #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step(5, 2, 1, 1'b1);
            vectors++;
            if (int'(accu) != exp_v[i]) begin
                errors++;
                $display("FAIL async_refill[%0d]: accu=%0d required=%0d", i, accu, exp_v[i]);
            end
        end
    endtask

    task automatic test_latency();
        int bseq[5]  = '{1, 2, 3, 3, 3};
        int exp_v[5] = '{0, 0, 1, 3, 6};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, bseq[i], 1'b1);
            vectors++;
            if (int'(accu) != exp_v[i]) begin
                errors++;
                $display("FAIL latency[%0d]: accu=%0d required=%0d", i, accu, exp_v[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                 int'($signed(8'($urandom))), 1'($urandom_range(0, 1)));
            vectors++;
            if (int'(accu) != model_acc) begin
                errors++;
                $display("FAIL random[%0d]: accu=%0d required=%0d", i, accu, model_acc);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        en  = 1'b0;
        x = '0; weight = '0; bias = '0;
        model_clear();
        test_reset();
        test_basic();
        test_repeated();
        test_en_gating();
        test_overflow();
        test_async_reset();
        test_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_accumulate
`default_nettype wire
